// File: rtl/fpu_pkg.sv
// Shared opcode, flag-index and state definitions for the multi-cycle arithmetic unit.
package fpu_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_MUL = 2;
  localparam int OP_DIV = 3;
  localparam int OP_REM = 4;

  localparam int FLG_CARRY = 0;
  localparam int FLG_OVF   = 1;
  localparam int FLG_DZ    = 2;
  localparam int FLG_ILL   = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } fpu_state_e;

endpackage

// File: rtl/fpu_iter_div.sv
// Restoring divider: one quotient bit per cycle over WIDTH cycles after start.
// done, quotient and remainder are valid together in the cycle of the final iteration.
module fpu_iter_div #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  logic [WIDTH:0]   shifted_d, diff_d;
  logic             fits_d;
  logic [WIDTH-1:0] rem_d, quo_d;
  logic             last_d;

  // Partial remainder stays below the divisor, so after the trial subtract it fits WIDTH bits.
  always_comb begin
    shifted_d = {rem_q, quo_q[WIDTH-1]};
    diff_d    = shifted_d - {1'b0, dvs_q};
    fits_d    = !diff_d[WIDTH];
    rem_d     = fits_d ? diff_d[WIDTH-1:0] : shifted_d[WIDTH-1:0];
    quo_d     = {quo_q[WIDTH-2:0], fits_d};
    last_d    = (cnt_q == CNT_W'(WIDTH - 1));
  end

  assign quotient  = quo_d;
  assign remainder = rem_d;
  assign done      = busy_q && last_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dvs_q  <= divisor;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + 1'b1;
      if (last_d) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fpu_mc.sv
// Multi-cycle handshaked integer unit: add/sub in one cycle, shift-add multiply and
// restoring divide/remainder over WIDTH iterations; one operation in flight at a time.
module fpu_mc
  import fpu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [OP_W-1:0]  fpu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int CNT_W = $clog2(WIDTH);

  fpu_state_e         state_q;
  logic               in_ready_q, out_valid_q, is_rem_q;
  logic [WIDTH-1:0]   result_q, mcand_q;
  logic [3:0]         flags_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               accept, is_div_op, div_start, div_done;
  logic [WIDTH:0]     add_d, mul_sum_d;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   div_quo, div_rem;

  // in_ready_q is only ever high in IDLE, so it doubles as the state qualifier.
  assign accept    = in_valid && in_ready_q;
  assign is_div_op = (fpu_op == OP_W'(OP_DIV)) || (fpu_op == OP_W'(OP_REM));
  assign div_start = accept && is_div_op && (|operand2);

  // Multiplier lives in the low half of acc_q and shifts out as the product shifts in.
  always_comb begin
    add_d     = {1'b0, operand1} + {1'b0, operand2};
    mul_sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_d     = {mul_sum_d, acc_q[WIDTH-1:1]};
  end

  fpu_iter_div #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .dividend  (operand1),
    .divisor   (operand2),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      is_rem_q    <= 1'b0;
      mcand_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
            case (fpu_op)
              OP_W'(OP_ADD): begin
                result_q           <= add_d[WIDTH-1:0];
                flags_q[FLG_CARRY] <= add_d[WIDTH];
                out_valid_q        <= 1'b1;
                state_q            <= ST_DONE;
              end
              OP_W'(OP_SUB): begin
                result_q           <= operand1 - operand2;
                flags_q[FLG_CARRY] <= (operand1 < operand2);
                out_valid_q        <= 1'b1;
                state_q            <= ST_DONE;
              end
              OP_W'(OP_MUL): begin
                mcand_q <= operand1;
                acc_q   <= {{WIDTH{1'b0}}, operand2};
                cnt_q   <= '0;
                state_q <= ST_MUL;
              end
              OP_W'(OP_DIV), OP_W'(OP_REM): begin
                is_rem_q <= (fpu_op == OP_W'(OP_REM));
                if (operand2 == '0) begin
                  result_q        <= (fpu_op == OP_W'(OP_REM)) ? operand1 : '1;
                  flags_q[FLG_DZ] <= 1'b1;
                  out_valid_q     <= 1'b1;
                  state_q         <= ST_DONE;
                end else begin
                  state_q <= ST_DIV;
                end
              end
              default: begin
                flags_q[FLG_ILL] <= 1'b1;
                out_valid_q      <= 1'b1;
                state_q          <= ST_DONE;
              end
            endcase
          end
        end
        ST_MUL: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            result_q         <= acc_d[WIDTH-1:0];
            flags_q[FLG_OVF] <= |acc_d[2*WIDTH-1:WIDTH];
            out_valid_q      <= 1'b1;
            state_q          <= ST_DONE;
          end
        end
        ST_DIV: begin
          if (div_done) begin
            result_q    <= is_rem_q ? div_rem : div_quo;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule
